// File: rtl/switch_pkg.sv
// Shared header offsets, byte type and transmit FSM states for the
// switch egress path.
package switch_pkg;

  localparam logic [1:0] HDR_DA  = 2'd0;
  localparam logic [1:0] HDR_SA  = 2'd1;
  localparam logic [1:0] HDR_LEN = 2'd2;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WLEN,
    PAY,
    DONE
  } tx_state_t;

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry register FIFO holding egress bytes with their SOP/EOP tags.
// Outputs are forced to zero whenever the buffer is empty.
module tx_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_sop_i,
  input  logic              push_eop_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o
);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic [1:0] occ_q, occ_d;
  ent_t       head_q, head_d;
  ent_t       tail_q, tail_d;
  ent_t       in_w;

  assign in_w = {push_sop_i, push_eop_i, push_data_i};

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_w;
        else               tail_d = in_w;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Push and pop together: occupancy is unchanged, the queue shifts.
        if (occ_q == 2'd1) begin
          head_d = in_w;
        end else begin
          head_d = tail_q;
          tail_d = in_w;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= 2'd0;
    else        occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign occ_o  = occ_q;
  assign vld_o  = (occ_q != 2'd0);
  assign data_o = vld_o ? head_q.data : '0;
  assign sop_o  = vld_o & head_q.sop;
  assign eop_o  = vld_o & head_q.eop;

endmodule

// File: rtl/switch_port_tx.sv
// Egress reader for one switch output port: drains the per-port packet FIFO
// (DA, SA, LEN, payload) onto a valid/ready stream with SOP/EOP framing.
module switch_port_tx
  import switch_pkg::*;
#(
  parameter int FIFO_SIZE = 64,
  parameter int W_WIDTH   = 8,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         port_en,
  input  logic [$clog2(FIFO_SIZE)-1:0] wr_pos,
  input  logic [$clog2(FIFO_SIZE)-1:0] rd_pos,
  input  logic [W_WIDTH-1:0]           fifo_data,
  output logic                         rd_en,
  output logic [W_WIDTH-1:0]           port_data,
  output logic                         port_valid,
  output logic                         port_sop,
  output logic                         port_eop,
  input  logic                         port_ready,
  output logic                         tx_busy,
  output logic [CNT_W-1:0]             pkt_cnt
);

  localparam int          PW   = $clog2(FIFO_SIZE);
  localparam logic [PW:0] FS_L = (PW+1)'(FIFO_SIZE);

  tx_state_t      state_q, state_d;
  logic [1:0]     hdr_idx_q, hdr_idx_d;
  byte_t          rem_q, rem_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic           infl_q;
  logic           sop_tag_q, sop_tag_d;
  logic           eop_tag_q, eop_tag_d;
  logic           len_tag_q, len_tag_d;

  logic [PW:0]    avail;
  logic           avail_nz;
  logic [1:0]     occ;
  logic [2:0]     credit_used;
  logic           credit_ok;
  logic           rd_want;
  logic           pop;
  logic           eop_pop;
  logic           push_eop;

  // Occupancy of the FIFO; pointer wrap is absorbed by the modulo subtraction.
  always_comb begin
    if (wr_pos >= rd_pos) avail = {1'b0, wr_pos} - {1'b0, rd_pos};
    else                  avail = {1'b0, wr_pos} + FS_L - {1'b0, rd_pos};
  end
  assign avail_nz = (avail != '0);

  assign pop         = port_valid & port_ready;
  assign eop_pop     = pop & port_eop;
  assign credit_used = {1'b0, occ} + {2'b00, infl_q};
  assign credit_ok   = credit_used < (3'd2 + {2'b00, pop});

  always_comb begin
    rd_want = 1'b0;
    case (state_q)
      IDLE:     rd_want = port_en & avail_nz;
      HDR, PAY: rd_want = 1'b1;
      default:  rd_want = 1'b0;
    endcase
  end

  // Reset also gates the strobe so the FIFO sees no read while rst_n is low.
  assign rd_en = rst_n & rd_want & avail_nz & credit_ok;

  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    rem_d     = rem_q;
    sop_tag_d = 1'b0;
    eop_tag_d = 1'b0;
    len_tag_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    if (eop_pop) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        hdr_idx_d = HDR_DA;
        if (rd_en) begin
          sop_tag_d = 1'b1;
          hdr_idx_d = HDR_SA;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (rd_en) begin
          if (hdr_idx_q == HDR_LEN) begin
            len_tag_d = 1'b1;
            state_d   = WLEN;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      WLEN: begin
        if (infl_q) begin
          rem_d   = fifo_data;
          state_d = (fifo_data == '0) ? DONE : PAY;
        end
      end
      PAY: begin
        if (rd_en) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            eop_tag_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (eop_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hdr_idx_q <= HDR_DA;
      infl_q    <= 1'b0;
      sop_tag_q <= 1'b0;
      eop_tag_q <= 1'b0;
      len_tag_q <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      infl_q    <= rd_en;
      sop_tag_q <= sop_tag_d;
      eop_tag_q <= eop_tag_d;
      len_tag_q <= len_tag_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
  end

  // A zero LEN byte closes the packet itself; known only when the byte lands.
  assign push_eop = eop_tag_q | (len_tag_q & (fifo_data == '0));

  tx_skid_buf #(
    .DATA_W(W_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (infl_q),
    .push_data_i(fifo_data),
    .push_sop_i (sop_tag_q),
    .push_eop_i (push_eop),
    .pop_i      (pop),
    .occ_o      (occ),
    .vld_o      (port_valid),
    .data_o     (port_data),
    .sop_o      (port_sop),
    .eop_o      (port_eop)
  );

  assign tx_busy = (state_q != IDLE) | rd_en;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_switch_port_tx.sv
// Directed bench for switch_port_tx with a behavioural packet FIFO in front
// and an occupancy/credit model watching the egress handshake.
module tb_switch_port_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        port_en;
  logic        port_ready;
  logic [5:0]  wr_pos;
  logic [5:0]  rd_pos;
  logic [7:0]  fifo_data;
  logic [7:0]  port_data;
  logic        rd_en;
  logic        port_valid;
  logic        port_sop;
  logic        port_eop;
  logic        tx_busy;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  switch_port_tx #(
    .FIFO_SIZE(64),
    .W_WIDTH  (8),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_en   (port_en),
    .wr_pos    (wr_pos),
    .rd_pos    (rd_pos),
    .fifo_data (fifo_data),
    .rd_en     (rd_en),
    .port_data (port_data),
    .port_valid(port_valid),
    .port_sop  (port_sop),
    .port_eop  (port_eop),
    .port_ready(port_ready),
    .tx_busy   (tx_busy),
    .pkt_cnt   (pkt_cnt)
  );

  // Packet FIFO model: data_out is valid the cycle after rd_en, 0 otherwise.
  logic [7:0] mem [64];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pos    <= 6'd0;
      fifo_data <= 8'h00;
    end else begin
      fifo_data <= rd_en ? mem[rd_pos] : 8'h00;
      if (rd_en) rd_pos <= rd_pos + 6'd1;
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic [7:0]       da;
    logic [7:0]       sa;
    logic [7:0]       len;
    logic [5:0][7:0]  pl;
    int               rmode;
    int               exp_beats;
    logic [7:0]       exp_eop;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    first_rd = -1;
  int    viol = 0;
  int    rmode = 0;
  beat_t cap [$];
  int    cap_cyc [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Egress monitor plus independent skid occupancy model.
  initial begin : monitor
    int occ_m;
    int infl_m;
    int popi;
    occ_m  = 0;
    infl_m = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ_m  = 0;
        infl_m = 0;
      end else begin
        popi = (port_valid && port_ready) ? 1 : 0;
        if (port_valid !== (occ_m != 0)) viol++;
        if (rd_en && (occ_m + infl_m - popi >= 2)) viol++;
        if (rd_en && (wr_pos == rd_pos)) viol++;
        if (rd_en && !tx_busy) viol++;
        if (rd_en && first_rd < 0) first_rd = cyc;
        if (popi == 1) begin
          cap.push_back({port_data, port_sop, port_eop});
          cap_cyc.push_back(cyc);
        end
        occ_m  = occ_m + infl_m - popi;
        infl_m = rd_en ? 1 : 0;
      end
    end
  end

  initial begin : ready_drv
    int rph;
    rph = 0;
    port_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) begin
        port_ready = (rph == 0);
        rph = (rph + 1) % 3;
      end else begin
        port_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    mem[wr_pos] = b;
    wr_pos = wr_pos + 6'd1;
  endtask

  task automatic wr_all(input logic [7:0] q [$]);
    foreach (q[i]) wr_byte(q[i]);
  endtask

  task automatic wait_cnt(input string nm, input int tgt, input int lim);
    int n = 0;
    while (int'(pkt_cnt) != tgt && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, ".pkt_cnt"}, 32'(pkt_cnt), tgt);
  endtask

  task automatic wait_beats(input string nm, input int k, input int lim);
    int n = 0;
    while (cap.size() < k && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, ".beats_seen"}, 32'(cap.size() >= k), 32'd1);
  endtask

  task automatic cmp_pkt(input string nm, input logic [7:0] q [$]);
    chk({nm, ".nbeats"}, cap.size(), q.size());
    for (int i = 0; i < q.size() && i < cap.size(); i++)
      chk($sformatf("%s.beat%0d", nm, i),
          32'({cap[i].d, cap[i].sop, cap[i].eop}),
          32'({q[i], (i == 0), (i == q.size() - 1)}));
  endtask

  initial begin : main
    vec_t       vecs [4];
    logic [7:0] exp_q [$];
    logic [7:0] p2_q [$];
    int         expc;
    string      nm;

    rst_n   = 1'b0;
    port_en = 1'b0;
    wr_pos  = 6'd0;

    vecs[0] = '{8'h11, 8'h22, 8'd2, 48'h0000_0000_A1A0, 0, 5, 8'hA1};
    vecs[1] = '{8'h33, 8'h44, 8'd0, 48'h0,              0, 3, 8'h00};
    vecs[2] = '{8'h55, 8'h66, 8'd4, 48'h0000_B3B2_B1B0, 1, 7, 8'hB3};
    vecs[3] = '{8'h77, 8'h88, 8'd1, 48'h0000_0000_00C0, 1, 4, 8'hC0};

    repeat (3) @(negedge clk);
    #1;
    chk("reset.outs", 32'({rd_en, port_valid, port_sop, port_eop, port_data, tx_busy}), 32'd0);
    chk("reset.pkt_cnt", 32'(pkt_cnt), 32'd0);
    rst_n = 1'b1;
    port_en = 1'b1;
    expc = 0;

    // Table-driven packets.
    for (int k = 0; k < 4; k++) begin
      nm = $sformatf("vec%0d", k);
      exp_q.delete();
      exp_q.push_back(vecs[k].da);
      exp_q.push_back(vecs[k].sa);
      exp_q.push_back(vecs[k].len);
      for (int j = 0; j < int'(vecs[k].len); j++) exp_q.push_back(vecs[k].pl[j]);
      cap.delete();
      cap_cyc.delete();
      first_rd = -1;
      viol = 0;
      rmode = vecs[k].rmode;
      tick();
      wr_all(exp_q);
      expc++;
      wait_cnt(nm, expc, 300);
      cmp_pkt(nm, exp_q);
      chk({nm, ".exp_beats"}, cap.size(), vecs[k].exp_beats);
      chk({nm, ".eop_byte"}, 32'((cap.size() > 0) ? cap[cap.size()-1].d : 8'hxx), 32'(vecs[k].exp_eop));
      if (vecs[k].rmode == 0)
        chk({nm, ".latency"}, (cap_cyc.size() > 0) ? cap_cyc[0] - first_rd : -1, 2);
      repeat (3) tick();
      chk({nm, ".idle"}, 32'({tx_busy, rd_en, port_valid}), 32'd0);
      chk({nm, ".drained"}, 32'(rd_pos), 32'(wr_pos));
      chk({nm, ".viol"}, viol, 0);
    end
    rmode = 0;

    // Trickling writer, one byte every 4 cycles, write pointer wraps mid-packet.
    exp_q.delete();
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'd50);
    for (int j = 0; j < 50; j++) exp_q.push_back(8'h40 + 8'(j));
    cap.delete();
    cap_cyc.delete();
    viol = 0;
    expc++;
    fork
      begin
        foreach (exp_q[i]) begin
          wr_byte(exp_q[i]);
          repeat (4) tick();
        end
      end
      wait_cnt("trickle", expc, 1000);
    join
    cmp_pkt("trickle", exp_q);
    chk("trickle.rd_pos", 32'(rd_pos), 32'd8);
    chk("trickle.viol", viol, 0);

    // port_en drops after the SOP beat; the second queued packet must wait.
    exp_q.delete();
    exp_q = '{8'h21, 8'h31, 8'd3, 8'hD0, 8'hD1, 8'hD2};
    p2_q  = '{8'h41, 8'h51, 8'd1, 8'hE0};
    cap.delete();
    cap_cyc.delete();
    viol = 0;
    tick();
    wr_all(exp_q);
    wr_all(p2_q);
    wait_beats("en_drop", 1, 50);
    port_en = 1'b0;
    expc++;
    wait_cnt("en_drop.p1", expc, 200);
    cmp_pkt("en_drop.p1", exp_q);
    repeat (20) tick();
    chk("en_drop.hold_avail", 32'(6'(wr_pos - rd_pos)), 32'd4);
    chk("en_drop.hold_cnt", 32'(pkt_cnt), expc);
    chk("en_drop.hold_beats", cap.size(), 6);
    chk("en_drop.hold_busy", 32'({tx_busy, rd_en}), 32'd0);
    cap.delete();
    cap_cyc.delete();
    port_en = 1'b1;
    expc++;
    wait_cnt("en_drop.p2", expc, 200);
    cmp_pkt("en_drop.p2", p2_q);
    chk("en_drop.viol", viol, 0);

    // Asynchronous reset in the middle of the payload.
    exp_q.delete();
    exp_q = '{8'h61, 8'h62, 8'd6, 8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
    cap.delete();
    cap_cyc.delete();
    tick();
    wr_all(exp_q);
    wait_beats("midrst", 5, 100);
    rst_n  = 1'b0;
    wr_pos = 6'd0;
    #1;
    chk("midrst.outs", 32'({rd_en, port_valid, port_sop, port_eop, port_data, tx_busy}), 32'd0);
    chk("midrst.pkt_cnt", 32'(pkt_cnt), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("midrst.hold", 32'({rd_en, port_valid, port_data, tx_busy, pkt_cnt}), 32'd0);
    rst_n = 1'b1;

    exp_q.delete();
    exp_q = '{8'h11, 8'h22, 8'd2, 8'hA0, 8'hA1};
    cap.delete();
    cap_cyc.delete();
    first_rd = -1;
    viol = 0;
    tick();
    wr_all(exp_q);
    wait_cnt("after_rst", 1, 200);
    cmp_pkt("after_rst", exp_q);
    chk("after_rst.latency", (cap_cyc.size() > 0) ? cap_cyc[0] - first_rd : -1, 2);
    chk("after_rst.viol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
